id_exe_stage_reg: RTL

//  ID->EXE pipeline register of the 5-stage ARM core; directly downstream of hazard detection.

---
 rtl/id_exe_if.sv | 43 ++++
 rtl/id_exe_stage_reg.sv | 99 +++++++++
 2 files changed

// File: rtl/id_exe_if.sv
// ID->EXE stage register bus: decoded fields in from ID, registered copies out to EXE
// and the write-back view back to hazard detection.
interface id_exe_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              freeze, flush, hazard;
  logic [WORD_W-1:0] pc_in, val_rn_in, val_rm_in;
  logic              imm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [3:0]        dest_in, src1_in, src2_in, exe_cmd_in, status_in;
  logic              mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;

  logic [WORD_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic              imm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm_24_out;
  logic [3:0]        dest_out, src1_out, src2_out, exe_cmd_out, status_out;
  logic              mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic              exe_wb_en;
  logic [3:0]        exe_dest;
  logic              valid_out;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output freeze, flush, hazard, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, exe_cmd_in, status_in,
           mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in,
    input  pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
           dest_out, src1_out, src2_out, exe_cmd_out, status_out, mem_r_en_out,
           mem_w_en_out, wb_en_out, b_out, s_out, exe_wb_en, exe_dest, valid_out, bubble_cnt
  );

  modport slave (
    input  freeze, flush, hazard, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, exe_cmd_in, status_in,
           mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in,
    output pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
           dest_out, src1_out, src2_out, exe_cmd_out, status_out, mem_r_en_out,
           mem_w_en_out, wb_en_out, b_out, s_out, exe_wb_en, exe_dest, valid_out, bubble_cnt
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: bubble on hazard, kill on flush, hold on freeze,
// saturating count of hazard bubbles.
module id_exe_stage_reg #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input logic     clk,
  input logic     rst,
  id_exe_if.slave bus
);
  logic [WORD_W-1:0] r_pc, r_val_rn, r_val_rm;
  logic              r_imm;
  logic [11:0]       r_shift_operand;
  logic [23:0]       r_signed_imm_24;
  logic [3:0]        r_dest, r_src1, r_src2, r_exe_cmd, r_status;
  logic              r_mem_r_en, r_mem_w_en, r_wb_en, r_b, r_s;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_kill, w_bubble, w_cnt_sat;
  assign w_kill    = bus.flush | bus.hazard;
  // A flush coinciding with a hazard is a flush, so it is not counted as a bubble.
  assign w_bubble  = bus.hazard & ~bus.flush;
  assign w_cnt_sat = &r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_imm           <= 1'b0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_status        <= '0;
      r_exe_cmd       <= '0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_valid         <= 1'b0;
      r_bubble_cnt    <= '0;
    end else if (!bus.freeze) begin
      // Datapath fields load even for bubbles; only control is squashed.
      r_pc            <= bus.pc_in;
      r_val_rn        <= bus.val_rn_in;
      r_val_rm        <= bus.val_rm_in;
      r_imm           <= bus.imm_in;
      r_shift_operand <= bus.shift_operand_in;
      r_signed_imm_24 <= bus.signed_imm_24_in;
      r_dest          <= bus.dest_in;
      r_src1          <= bus.src1_in;
      r_src2          <= bus.src2_in;
      r_status        <= bus.status_in;
      if (w_kill) begin
        r_exe_cmd  <= '0;
        r_mem_r_en <= 1'b0;
        r_mem_w_en <= 1'b0;
        r_wb_en    <= 1'b0;
        r_b        <= 1'b0;
        r_s        <= 1'b0;
        r_valid    <= 1'b0;
        if (w_bubble && !w_cnt_sat) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end else begin
        r_exe_cmd  <= bus.exe_cmd_in;
        r_mem_r_en <= bus.mem_r_en_in;
        r_mem_w_en <= bus.mem_w_en_in;
        r_wb_en    <= bus.wb_en_in;
        r_b        <= bus.b_in;
        r_s        <= bus.s_in;
        r_valid    <= 1'b1;
      end
    end
  end

  assign bus.pc_out            = r_pc;
  assign bus.val_rn_out        = r_val_rn;
  assign bus.val_rm_out        = r_val_rm;
  assign bus.imm_out           = r_imm;
  assign bus.shift_operand_out = r_shift_operand;
  assign bus.signed_imm_24_out = r_signed_imm_24;
  assign bus.dest_out          = r_dest;
  assign bus.src1_out          = r_src1;
  assign bus.src2_out          = r_src2;
  assign bus.status_out        = r_status;
  assign bus.exe_cmd_out       = r_exe_cmd;
  assign bus.mem_r_en_out      = r_mem_r_en;
  assign bus.mem_w_en_out      = r_mem_w_en;
  assign bus.wb_en_out         = r_wb_en;
  assign bus.b_out             = r_b;
  assign bus.s_out             = r_s;
  assign bus.exe_wb_en         = r_wb_en;
  assign bus.exe_dest          = r_dest;
  assign bus.valid_out         = r_valid;
  assign bus.bubble_cnt        = r_bubble_cnt;
endmodule
